// File: rtl/mips_regfile.sv
// MIPS general-purpose register file: two combinational read ports, one
// clocked write port, register 0 hardwired to zero. Optional write-through
// bypass forwards same-cycle write data to a read port addressing the target.
module mips_regfile #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter bit          BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2
);

  localparam int unsigned NumRegs = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NumRegs];

  logic wr_en;
  logic byp1;
  logic byp2;

  // A write to r0 is dropped here, so regs_q[0] stays at its reset value of 0.
  assign wr_en = we && (wa != '0);

  // Forwarding is gated by rst_n so reads stay 0 for the whole reset window.
  assign byp1 = BYPASS && wr_en && rst_n && (ra1 == wa);
  assign byp2 = BYPASS && wr_en && rst_n && (ra2 == wa);

  // Register array with asynchronous clear; reset takes priority over a write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NumRegs; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[wa] <= wd;
    end
  end

  // Read port 1: zero for r0, bypassed write data, else stored value.
  always_comb begin
    rd1 = '0;
    if (ra1 != '0) begin
      if (byp1) begin
        rd1 = wd;
      end else begin
        rd1 = regs_q[ra1];
      end
    end
  end

  // Read port 2: resolved independently with the same rules as port 1.
  always_comb begin
    rd2 = '0;
    if (ra2 != '0) begin
      if (byp2) begin
        rd2 = wd;
      end else begin
        rd2 = regs_q[ra2];
      end
    end
  end

endmodule
